// File: rtl/delayed_assign_pipe.sv
// delayed_assign_pipe
// Clocked stand-in for an intra-assignment-delayed operation (w = #N a op b).
// Each accepted operand pair is combined lane by lane with a bitwise operator
// chosen by in_mode, and the result emerges exactly DEPTH cycles later.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   flush        discard every in-flight entry on the next edge
//   in_valid     operand pair present
//   in_ready     pipe accepts input this cycle (combinational)
//   in_a, in_b   CHANNELS lanes of WIDTH bits, lane k at [k*WIDTH +: WIDTH]
//   in_mode      00 AND, 01 OR, 10 XOR, 11 pass A
//   out_valid    result present at the last stage
//   out_ready    downstream accepts the result
//   out_data     result, packed like the operands
//   occupancy    number of valid entries held in the pipe
module delayed_assign_pipe #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DEPTH    = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [CHANNELS*WIDTH-1:0]     in_a,
    input  logic [CHANNELS*WIDTH-1:0]     in_b,
    input  logic [1:0]                    in_mode,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CHANNELS*WIDTH-1:0]     out_data,
    output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

    localparam int unsigned DATA_W = CHANNELS * WIDTH;
    localparam int unsigned OCC_W  = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        MODE_AND  = 2'b00,
        MODE_OR   = 2'b01,
        MODE_XOR  = 2'b10,
        MODE_PASS = 2'b11
    } mode_e;

    // Reject out-of-range latencies at elaboration.
    if (DEPTH < 1 || DEPTH > 16) begin : g_depth_check
        $error("delayed_assign_pipe: DEPTH must be in 1..16");
    end

    logic [DATA_W-1:0] op_result_c;
    logic [DATA_W-1:0] stage_data [DEPTH];
    logic [DEPTH-1:0]  stage_valid;

    logic advance_c;
    logic accept_c;
    logic xfer_c;

    // Per-lane operator; lanes never interact, so each is its own slice.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        logic [WIDTH-1:0] lane_a;
        logic [WIDTH-1:0] lane_b;
        logic [WIDTH-1:0] lane_r;

        assign lane_a = in_a[k*WIDTH +: WIDTH];
        assign lane_b = in_b[k*WIDTH +: WIDTH];

        always_comb begin
            lane_r = lane_a;
            case (mode_e'(in_mode))
                MODE_AND:  lane_r = lane_a & lane_b;
                MODE_OR:   lane_r = lane_a | lane_b;
                MODE_XOR:  lane_r = lane_a ^ lane_b;
                MODE_PASS: lane_r = lane_a;
                default:   lane_r = lane_a;
            endcase
        end

        assign op_result_c[k*WIDTH +: WIDTH] = lane_r;
    end

    // Global stall: every stage moves unless the head is held by downstream.
    assign advance_c = out_ready | ~stage_valid[DEPTH-1];
    assign in_ready  = advance_c & ~flush & ~rst;
    assign accept_c  = in_valid & in_ready;
    assign xfer_c    = out_valid & out_ready;

    assign out_valid = stage_valid[DEPTH-1];
    assign out_data  = stage_data[DEPTH-1];

    // Stage registers; flush only drops valid bits, data is left in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_data[i] <= '0;
            end
        end else if (flush) begin
            stage_valid <= '0;
        end else if (advance_c) begin
            stage_valid[0] <= accept_c;
            if (accept_c) begin
                stage_data[0] <= op_result_c;
            end
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_valid[i] <= stage_valid[i-1];
                stage_data[i]  <= stage_data[i-1];
            end
        end
    end

    // Occupancy tracks accepts minus deliveries; a flush empties the pipe.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occupancy <= '0;
        end else if (accept_c && !xfer_c) begin
            occupancy <= occupancy + OCC_W'(1);
        end else if (xfer_c && !accept_c) begin
            occupancy <= occupancy - OCC_W'(1);
        end
    end

endmodule

// File: tb/tb_delayed_assign_pipe.sv
// Bench for delayed_assign_pipe: a default build (8x4, DEPTH 3) driven by
// directed vector tables and corner sequences, plus a 1x1 DEPTH 1 build.
// Both builds then run random handshakes against an entry/position model.
module tb_delayed_assign_pipe;

    localparam int MDEPTH = 3;

    logic clk;
    logic rst;

    logic        m_flush, m_in_valid, m_in_ready, m_out_valid, m_out_ready;
    logic [31:0] m_in_a, m_in_b, m_out_data;
    logic [1:0]  m_in_mode;
    logic [1:0]  m_occupancy;

    logic        s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic        s_in_a, s_in_b, s_out_data;
    logic [1:0]  s_in_mode;
    logic        s_occupancy;

    int n_checks;
    int n_fail;

    delayed_assign_pipe #(.WIDTH(8), .CHANNELS(4), .DEPTH(MDEPTH)) u_main (
        .clk(clk), .rst(rst), .flush(m_flush),
        .in_valid(m_in_valid), .in_ready(m_in_ready),
        .in_a(m_in_a), .in_b(m_in_b), .in_mode(m_in_mode),
        .out_valid(m_out_valid), .out_ready(m_out_ready),
        .out_data(m_out_data), .occupancy(m_occupancy)
    );

    delayed_assign_pipe #(.WIDTH(1), .CHANNELS(1), .DEPTH(1)) u_small (
        .clk(clk), .rst(rst), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_a(s_in_a), .in_b(s_in_b), .in_mode(s_in_mode),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .occupancy(s_occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [5];

    // Reference model: in-order list of entries, each with the number of
    // stage moves it has made since accept. Index 0 is the oldest.
    logic [31:0] md_dat [2][17];
    int          md_pos [2][17];
    int          md_cnt [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
        case (m)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return a;
        endcase
    endfunction

    function automatic logic model_ov(input int u, input int depth);
        return (md_cnt[u] > 0) && (md_pos[u][0] == depth - 1);
    endfunction

    task automatic model_step(input int u, input int depth, input logic inv, input logic outr,
                              input logic fl, input logic [31:0] res);
        logic ov, adv, acc;
        ov  = model_ov(u, depth);
        adv = outr || !ov;
        acc = inv && adv && !fl;
        if (ov && outr) begin
            for (int k = 1; k < md_cnt[u]; k++) begin
                md_dat[u][k-1] = md_dat[u][k];
                md_pos[u][k-1] = md_pos[u][k];
            end
            md_cnt[u]--;
        end
        if (fl) begin
            md_cnt[u] = 0;
        end else begin
            if (adv) begin
                for (int k = 0; k < md_cnt[u]; k++) md_pos[u][k]++;
            end
            if (acc) begin
                md_dat[u][md_cnt[u]] = res;
                md_pos[u][md_cnt[u]] = 0;
                md_cnt[u]++;
            end
        end
    endtask

    task automatic check_unit(input int u, input int depth, input logic inr, input logic ov,
                              input int unsigned occ, input logic [31:0] od,
                              input logic fl, input logic outr);
        string p;
        logic  e_ov;
        p    = (u == 0) ? "rnd main" : "rnd small";
        e_ov = model_ov(u, depth);
        chk({p, " in_ready"}, 64'(inr), 64'(!fl && (outr || !e_ov)));
        chk({p, " out_valid"}, 64'(ov), 64'(e_ov));
        chk({p, " occupancy"}, 64'(occ), 64'(md_cnt[u]));
        chk({p, " occupancy range"}, 64'(occ <= 32'(depth)), 64'(1));
        if (e_ov) chk({p, " out_data"}, 64'(od), 64'(md_dat[u][0]));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_main(input int idx, input logic v);
        m_in_valid = v;
        if (v) begin
            m_in_mode = vecs[idx].mode;
            m_in_a    = vecs[idx].a;
            m_in_b    = vecs[idx].b;
        end
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int k;
        int peak;
        int acc_b, xf_b;
        logic exp_v;
        int drain_occ [7];

        n_checks = 0;
        n_fail   = 0;
        md_cnt[0] = 0;
        md_cnt[1] = 0;
        drain_occ = '{3, 3, 3, 2, 1, 0, 0};

        vecs[0] = '{2'b00, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
        vecs[1] = '{2'b00, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'h000F_000F};
        vecs[2] = '{2'b01, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'h0FFF_0FFF};
        vecs[3] = '{2'b10, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'h0FF0_0FF0};
        vecs[4] = '{2'b11, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'h0F0F_0F0F};

        rst = 1'b1;
        m_flush = 1'b0; m_in_valid = 1'b0; m_out_ready = 1'b1;
        m_in_a = '0; m_in_b = '0; m_in_mode = '0;
        s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b1;
        s_in_a = '0; s_in_b = '0; s_in_mode = '0;

        // Reset state.
        tick();
        @(negedge clk);
        chk("in_ready during rst", 64'(m_in_ready), 64'(0));
        chk("small in_ready during rst", 64'(s_in_ready), 64'(0));
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset in_ready", 64'(m_in_ready), 64'(1));
        chk("reset out_valid", 64'(m_out_valid), 64'(0));
        chk("reset out_data", 64'(m_out_data), 64'(0));
        chk("reset occupancy", 64'(m_occupancy), 64'(0));
        chk("small reset out_valid", 64'(s_out_valid), 64'(0));
        chk("small reset occupancy", 64'(s_occupancy), 64'(0));
        tick();

        // Streaming table with out_ready held high.
        peak = 0;
        for (int c = 0; c < 5 + MDEPTH + 1; c++) begin
            drive_main(c, c < 5);
            m_out_ready = 1'b1;
            @(negedge clk);
            chk("stream in_ready", 64'(m_in_ready), 64'(1));
            exp_v = (c >= MDEPTH) && (c - MDEPTH < 5);
            chk("stream out_valid", 64'(m_out_valid), 64'(exp_v));
            if (exp_v) chk("stream out_data", 64'(m_out_data), 64'(vecs[c-MDEPTH].exp));
            acc_b = (c < 5) ? c : 5;
            xf_b  = (c - MDEPTH < 0) ? 0 : ((c - MDEPTH > 5) ? 5 : c - MDEPTH);
            chk("stream occupancy", 64'(m_occupancy), 64'(acc_b - xf_b));
            if (int'(m_occupancy) > peak) peak = int'(m_occupancy);
            tick();
        end
        chk("stream occupancy peak", 64'(peak), 64'(MDEPTH));

        // Backpressure: three accepts fill the pipe, then everything holds.
        k = 0;
        m_out_ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            drive_main(k, k < 5);
            @(negedge clk);
            chk("stall in_ready", 64'(m_in_ready), 64'(c < 3));
            chk("stall occupancy", 64'(m_occupancy), 64'((c < 3) ? c : 3));
            chk("stall out_valid", 64'(m_out_valid), 64'(c >= 3));
            if (c >= 3) chk("stall out_data frozen", 64'(m_out_data), 64'(vecs[0].exp));
            if (c < 3) k++;
            tick();
        end
        m_out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            drive_main(k, k < 5);
            @(negedge clk);
            chk("drain in_ready", 64'(m_in_ready), 64'(1));
            chk("drain out_valid", 64'(m_out_valid), 64'(c < 5));
            if (c < 5) chk("drain out_data", 64'(m_out_data), 64'(vecs[c].exp));
            chk("drain occupancy", 64'(m_occupancy), 64'(drain_occ[c]));
            if (c < 2) k++;
            tick();
        end

        // Flush with three entries in flight and a competing input.
        m_out_ready = 1'b0;
        for (int c = 1; c < 4; c++) begin
            drive_main(c, 1'b1);
            tick();
        end
        drive_main(4, 1'b1);
        m_flush = 1'b1;
        @(negedge clk);
        chk("flush in_ready", 64'(m_in_ready), 64'(0));
        chk("flush pre occupancy", 64'(m_occupancy), 64'(3));
        tick();
        m_flush = 1'b0;
        m_in_valid = 1'b0;
        m_out_ready = 1'b1;
        for (int c = 0; c < MDEPTH + 3; c++) begin
            @(negedge clk);
            chk("post flush out_valid", 64'(m_out_valid), 64'(0));
            chk("post flush occupancy", 64'(m_occupancy), 64'(0));
            tick();
        end

        // Reset with two entries in flight, then a single clean transaction.
        m_out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            drive_main(c, 1'b1);
            tick();
        end
        m_in_valid = 1'b0;
        @(negedge clk);
        chk("pre reset occupancy", 64'(m_occupancy), 64'(2));
        tick();
        rst = 1'b1;
        drive_main(3, 1'b1);
        @(negedge clk);
        chk("mid reset in_ready", 64'(m_in_ready), 64'(0));
        tick();
        rst = 1'b0;
        m_in_valid = 1'b0;
        @(negedge clk);
        chk("after reset out_valid", 64'(m_out_valid), 64'(0));
        chk("after reset out_data", 64'(m_out_data), 64'(0));
        chk("after reset occupancy", 64'(m_occupancy), 64'(0));
        chk("after reset in_ready", 64'(m_in_ready), 64'(1));
        tick();
        m_out_ready = 1'b1;
        for (int c = 0; c < MDEPTH + 3; c++) begin
            drive_main(2, c == 0);
            @(negedge clk);
            chk("post reset out_valid", 64'(m_out_valid), 64'(c == MDEPTH));
            if (c == MDEPTH) chk("post reset out_data", 64'(m_out_data), 64'(vecs[2].exp));
            tick();
        end

        // Random handshakes on both builds against the entry model.
        reset_pulse();
        md_cnt[0] = 0;
        md_cnt[1] = 0;
        for (int c = 0; c < 1500; c++) begin
            m_in_valid  = ($urandom_range(0, 3) != 0);
            m_out_ready = ($urandom_range(0, 2) != 0);
            m_flush     = ($urandom_range(0, 24) == 0);
            m_in_mode   = 2'($urandom_range(0, 3));
            m_in_a      = $urandom;
            m_in_b      = $urandom;
            s_in_valid  = ($urandom_range(0, 3) != 0);
            s_out_ready = ($urandom_range(0, 2) != 0);
            s_flush     = ($urandom_range(0, 24) == 0);
            s_in_mode   = 2'($urandom_range(0, 3));
            s_in_a      = 1'($urandom);
            s_in_b      = 1'($urandom);
            @(negedge clk);
            check_unit(0, MDEPTH, m_in_ready, m_out_valid, 32'(m_occupancy), m_out_data,
                       m_flush, m_out_ready);
            check_unit(1, 1, s_in_ready, s_out_valid, 32'(s_occupancy), 32'(s_out_data),
                       s_flush, s_out_ready);
            model_step(0, MDEPTH, m_in_valid, m_out_ready, m_flush,
                       ref_op(m_in_mode, m_in_a, m_in_b));
            model_step(1, 1, s_in_valid, s_out_ready, s_flush,
                       ref_op(s_in_mode, 32'(s_in_a), 32'(s_in_b)) & 32'h1);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
